// File: rtl/pe_group_tile_sequencer.sv
// pe_group_tile_sequencer
// Walks one PE_Group through whole tiles: opens the W/I/O operand streams
// block by block with fixed per-block word budgets, then forwards the
// tile's finished output words downstream before starting the next tile.
// All data paths are combinational pass-through; only handshakes are gated.
module pe_group_tile_sequencer #(
    parameter int DataWidth       = 32,
    parameter int W_PEGroupSize   = 4,
    parameter int I_PEGroupSize   = 7,
    parameter int O_PEGroupSize   = 4,
    parameter int BlockCount      = 4,
    parameter int BlockCountWidth = 2,
    parameter int TileCountWidth  = 8
) (
    input  logic                       clk,
    input  logic                       aclr_n,
    input  logic                       start,
    input  logic [TileCountWidth-1:0]  num_tiles,
    output logic                       busy,
    output logic                       done,
    output logic [TileCountWidth-1:0]  tile_idx,
    output logic [BlockCountWidth-1:0] block_idx,
    input  logic                       s_w_valid,
    output logic                       s_w_rdy,
    input  logic [DataWidth-1:0]       s_w_data,
    input  logic                       s_i_valid,
    output logic                       s_i_rdy,
    input  logic [DataWidth-1:0]       s_i_data,
    input  logic                       s_o_valid,
    output logic                       s_o_rdy,
    input  logic [DataWidth-1:0]       s_o_data,
    output logic                       pe_w_valid,
    input  logic                       pe_w_rdy,
    output logic [DataWidth-1:0]       pe_w_data,
    output logic                       pe_i_valid,
    input  logic                       pe_i_rdy,
    output logic [DataWidth-1:0]       pe_i_data,
    output logic                       pe_o_valid,
    input  logic                       pe_o_rdy,
    output logic [DataWidth-1:0]       pe_o_data,
    input  logic                       pe_out_valid,
    output logic                       pe_out_rdy,
    input  logic [DataWidth-1:0]       pe_out_data,
    output logic                       m_valid,
    input  logic                       m_rdy,
    output logic [DataWidth-1:0]       m_data
);

    // Counters must hold the largest per-block budget without wrapping.
    localparam int CntMax0  = (I_PEGroupSize > O_PEGroupSize) ? I_PEGroupSize : O_PEGroupSize;
    localparam int CntMax   = (CntMax0 > W_PEGroupSize) ? CntMax0 : W_PEGroupSize;
    localparam int CntWidth = $clog2(CntMax + 1);

    localparam logic [CntWidth-1:0]        WLim      = CntWidth'(W_PEGroupSize);
    localparam logic [CntWidth-1:0]        ILimFirst = CntWidth'(I_PEGroupSize);
    localparam logic [CntWidth-1:0]        OLim      = CntWidth'(O_PEGroupSize);
    localparam logic [CntWidth-1:0]        OutLast   = CntWidth'(O_PEGroupSize - 1);
    localparam logic [BlockCountWidth-1:0] LastBlock = BlockCountWidth'(BlockCount - 1);

    typedef enum logic [1:0] {IDLE, BLOCK, DRAIN, FIN} state_e;

    state_e                      state_q, state_d;
    logic [TileCountWidth-1:0]   num_tiles_q, num_tiles_d;
    logic [TileCountWidth-1:0]   tile_idx_q, tile_idx_d;
    logic [BlockCountWidth-1:0]  block_idx_q, block_idx_d;
    logic [CntWidth-1:0]         w_cnt_q, w_cnt_d;
    logic [CntWidth-1:0]         i_cnt_q, i_cnt_d;
    logic [CntWidth-1:0]         o_cnt_q, o_cnt_d;
    logic [CntWidth-1:0]         out_cnt_q, out_cnt_d;

    logic [CntWidth-1:0]         i_lim;
    logic                        wen, ien, oen;
    logic                        block_complete;
    logic                        draining;
    logic [TileCountWidth-1:0]   tile_next;

    // Operand and result words flow straight through; only valid/rdy are gated.
    assign pe_w_data = s_w_data;
    assign pe_i_data = s_i_data;
    assign pe_o_data = s_o_data;
    assign m_data    = pe_out_data;
    assign tile_idx  = tile_idx_q;
    assign block_idx = block_idx_q;
    assign tile_next = tile_idx_q + 1'b1;

    // State register: FSM state, latched tile count, indices and word counters.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q     <= IDLE;
            num_tiles_q <= '0;
            tile_idx_q  <= '0;
            block_idx_q <= '0;
            w_cnt_q     <= '0;
            i_cnt_q     <= '0;
            o_cnt_q     <= '0;
            out_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            num_tiles_q <= num_tiles_d;
            tile_idx_q  <= tile_idx_d;
            block_idx_q <= block_idx_d;
            w_cnt_q     <= w_cnt_d;
            i_cnt_q     <= i_cnt_d;
            o_cnt_q     <= o_cnt_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    // Next-state: block advance on registered counts, drain exit on the last output transfer.
    always_comb begin
        state_d     = state_q;
        num_tiles_d = num_tiles_q;
        tile_idx_d  = tile_idx_q;
        block_idx_d = block_idx_q;
        w_cnt_d     = w_cnt_q;
        i_cnt_d     = i_cnt_q;
        o_cnt_d     = o_cnt_q;
        out_cnt_d   = out_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_tiles_d = num_tiles;
                    tile_idx_d  = '0;
                    block_idx_d = '0;
                    w_cnt_d     = '0;
                    i_cnt_d     = '0;
                    o_cnt_d     = '0;
                    out_cnt_d   = '0;
                    state_d     = (num_tiles == '0) ? FIN : BLOCK;
                end
            end
            BLOCK: begin
                if (block_complete) begin
                    w_cnt_d = '0;
                    i_cnt_d = '0;
                    o_cnt_d = '0;
                    if (block_idx_q != LastBlock) begin
                        block_idx_d = block_idx_q + 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    if (pe_w_valid && pe_w_rdy) w_cnt_d = w_cnt_q + 1'b1;
                    if (pe_i_valid && pe_i_rdy) i_cnt_d = i_cnt_q + 1'b1;
                    if (pe_o_valid && pe_o_rdy) o_cnt_d = o_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (m_valid && m_rdy) begin
                    if (out_cnt_q == OutLast) begin
                        out_cnt_d   = '0;
                        block_idx_d = '0;
                        tile_idx_d  = tile_next;
                        state_d     = (tile_next == num_tiles_q) ? FIN : BLOCK;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: per-stream enables from the budgets, handshake gating, status flags.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        i_lim          = (block_idx_q == '0) ? ILimFirst : WLim;
        wen            = (state_q == BLOCK) && (w_cnt_q < WLim);
        ien            = (state_q == BLOCK) && (i_cnt_q < i_lim);
        oen            = (state_q == BLOCK) && (block_idx_q == '0) && (o_cnt_q < OLim);
        block_complete = (w_cnt_q == WLim) && (i_cnt_q == i_lim)
                         && ((block_idx_q != '0) || (o_cnt_q == OLim));
        draining       = (state_q == DRAIN);
        pe_w_valid     = s_w_valid & wen;
        s_w_rdy        = pe_w_rdy & wen;
        pe_i_valid     = s_i_valid & ien;
        s_i_rdy        = pe_i_rdy & ien;
        pe_o_valid     = s_o_valid & oen;
        s_o_rdy        = pe_o_rdy & oen;
        m_valid        = pe_out_valid & draining;
        pe_out_rdy     = m_rdy & draining;
        busy           = (state_q != IDLE);
        done           = (state_q == FIN);
    end

endmodule

// File: tb/tb_pe_group_tile_sequencer.sv
// Testbench for pe_group_tile_sequencer: a table of tile-run scenarios driven
// cycle by cycle against a small handshake model, plus hand-written sequences
// for reset, zero tiles and a mid-block asynchronous abort.
module tb_pe_group_tile_sequencer;

    localparam int DW  = 32;
    localparam int TCW = 8;
    localparam int BCW = 2;

    logic           clk, aclr_n, start;
    logic [TCW-1:0] num_tiles;
    logic           busy, done;
    logic [TCW-1:0] tile_idx;
    logic [BCW-1:0] block_idx;
    logic           s_w_valid, s_w_rdy, s_i_valid, s_i_rdy, s_o_valid, s_o_rdy;
    logic [DW-1:0]  s_w_data, s_i_data, s_o_data;
    logic           pe_w_valid, pe_w_rdy, pe_i_valid, pe_i_rdy, pe_o_valid, pe_o_rdy;
    logic [DW-1:0]  pe_w_data, pe_i_data, pe_o_data;
    logic           pe_out_valid, pe_out_rdy, m_valid, m_rdy;
    logic [DW-1:0]  pe_out_data, m_data;

    pe_group_tile_sequencer #(
        .DataWidth(DW), .W_PEGroupSize(4), .I_PEGroupSize(7), .O_PEGroupSize(4),
        .BlockCount(4), .BlockCountWidth(BCW), .TileCountWidth(TCW)
    ) dut (
        .clk(clk), .aclr_n(aclr_n), .start(start), .num_tiles(num_tiles),
        .busy(busy), .done(done), .tile_idx(tile_idx), .block_idx(block_idx),
        .s_w_valid(s_w_valid), .s_w_rdy(s_w_rdy), .s_w_data(s_w_data),
        .s_i_valid(s_i_valid), .s_i_rdy(s_i_rdy), .s_i_data(s_i_data),
        .s_o_valid(s_o_valid), .s_o_rdy(s_o_rdy), .s_o_data(s_o_data),
        .pe_w_valid(pe_w_valid), .pe_w_rdy(pe_w_rdy), .pe_w_data(pe_w_data),
        .pe_i_valid(pe_i_valid), .pe_i_rdy(pe_i_rdy), .pe_i_data(pe_i_data),
        .pe_o_valid(pe_o_valid), .pe_o_rdy(pe_o_rdy), .pe_o_data(pe_o_data),
        .pe_out_valid(pe_out_valid), .pe_out_rdy(pe_out_rdy), .pe_out_data(pe_out_data),
        .m_valid(m_valid), .m_rdy(m_rdy), .m_data(m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        int    n_tiles;
        bit    rdy_toggle;  // pe_w_rdy / pe_i_rdy alternate every cycle
        bit    m_stall;     // m_rdy low for the first 5 drain cycles of each tile
        bit    i_stall;     // s_i_valid low for 10 cycles on entering tile 0 block 2
        bit    glitch;      // extra start pulse while busy
        int    exp_w, exp_i, exp_o, exp_m;
    } scen_t;

    scen_t tbl[5];

    function automatic logic [63:0] tag(input int t, input int b, input logic [31:0] d);
        return {8'(t), 8'(b), 16'h0, d};
    endfunction

    function automatic logic [7:0] hs_bundle();
        return {pe_w_valid, s_w_rdy, pe_i_valid, s_i_rdy, pe_o_valid, s_o_rdy, m_valid, pe_out_rdy};
    endfunction

    task automatic drive_all_ready();
        s_w_valid = 1'b1; s_w_data = 32'h11;
        s_i_valid = 1'b1; s_i_data = 32'h22;
        s_o_valid = 1'b1; s_o_data = 32'h33;
        pe_w_rdy = 1'b1; pe_i_rdy = 1'b1; pe_o_rdy = 1'b1;
        pe_out_valid = 1'b1; pe_out_data = 32'h44; m_rdy = 1'b1;
    endtask

    task automatic run_scenario(input scen_t s);
        logic [63:0] got_w[$], got_i[$], got_o[$];
        logic [31:0] got_m[$];
        int wi = 0, ii = 0, oi = 0, pi = 0;
        int sw = 0, si = 0, so = 0, sout = 0, drain_cyc = 0;
        int cur_tile = -1, cur_block = -1;
        int ti, bi, lim_i, exp_b, istall_cnt = 0;
        bit istall_done = 0, finished = 0, stall_i;
        bit prev_active = 0, prev_full = 0, prev_drain = 0, prev_done = 0, prev_last_out = 0;
        int prev_block = 0, prev_tile = 0;
        bit full, active, drain_exp, en_w, en_i, en_o, done_exp, xm;
        int viol = 0, done_cnt = 0, n;

        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(posedge clk); #1;
            ti = int'(tile_idx);
            bi = int'(block_idx);
            if (ti != cur_tile || bi != cur_block) begin
                sw = 0; si = 0; so = 0; sout = 0; drain_cyc = 0;
                cur_tile = ti; cur_block = bi;
            end
            // Sequencing relative to what was seen last cycle.
            if (prev_active && !prev_drain) begin
                exp_b = (prev_full && prev_block < 3) ? prev_block + 1 : prev_block;
                if (bi != exp_b || ti != prev_tile) viol++;
            end
            if (prev_drain) begin
                if (prev_last_out) begin
                    if (ti != (prev_tile + 1) % 256 || bi != 0) viol++;
                end else if (ti != prev_tile || bi != 3) begin
                    viol++;
                end
            end
            done_exp = prev_last_out && (prev_tile + 1 == s.n_tiles);
            if (done !== done_exp) viol++;
            if (prev_done && busy !== 1'b0) viol++;
            if (prev_active && busy !== 1'b1) viol++;
            if (cyc == 1 && busy !== 1'b1) viol++;

            // Handshake model for this cycle, from counts of observed transfers.
            lim_i     = (bi == 0) ? 7 : 4;
            full      = (sw == 4) && (si == lim_i) && (bi != 0 || so == 4);
            active    = (busy === 1'b1) && (done === 1'b0);
            drain_exp = active && bi == 3 && full && prev_active && prev_full
                        && prev_block == 3 && prev_tile == ti;
            en_w      = active && sw < 4;
            en_i      = active && si < lim_i;
            en_o      = active && bi == 0 && so < 4;

            stall_i = 1'b0;
            if (s.i_stall && !istall_done && active && ti == 0 && bi == 2) begin
                if (istall_cnt == 10) begin
                    istall_done = 1'b1;
                    check({s.name, "_stall_block_held"}, 64'(bi), 64'd2);
                    check({s.name, "_stall_w_alone"}, 64'(sw), 64'd4);
                    check({s.name, "_stall_no_i"}, 64'(si), 64'd0);
                end else begin
                    stall_i = 1'b1;
                    istall_cnt++;
                end
            end

            s_w_valid    = (wi < s.exp_w + 3);
            s_w_data     = 32'(5 * (wi + 1));
            s_i_valid    = (ii < s.exp_i + 3) && !stall_i;
            s_i_data     = 32'(ii + 1);
            s_o_valid    = (oi < s.exp_o + 3);
            s_o_data     = 32'(10 * (oi + 1));
            pe_w_rdy     = s.rdy_toggle ? ((cyc % 2) == 1) : 1'b1;
            pe_i_rdy     = s.rdy_toggle ? ((cyc % 2) == 0) : 1'b1;
            pe_o_rdy     = 1'b1;
            pe_out_valid = 1'b1;
            pe_out_data  = 32'hA000_0000 + 32'(pi);
            m_rdy        = !(s.m_stall && drain_exp && drain_cyc < 5);
            if (drain_exp) drain_cyc++;
            start        = (cyc == 0) || (s.glitch && cyc == 40);
            num_tiles    = (cyc == 0) ? TCW'(s.n_tiles) : TCW'(s.n_tiles + 5);

            @(negedge clk);
            if (pe_w_valid !== (s_w_valid & en_w) || s_w_rdy !== (pe_w_rdy & en_w)) viol++;
            if (pe_i_valid !== (s_i_valid & en_i) || s_i_rdy !== (pe_i_rdy & en_i)) viol++;
            if (pe_o_valid !== (s_o_valid & en_o) || s_o_rdy !== (pe_o_rdy & en_o)) viol++;
            if (m_valid !== (pe_out_valid & drain_exp) || pe_out_rdy !== (m_rdy & drain_exp)) viol++;
            if (pe_w_data !== s_w_data || pe_i_data !== s_i_data || pe_o_data !== s_o_data) viol++;
            if (m_data !== pe_out_data) viol++;

            if (s_w_valid && s_w_rdy) begin
                got_w.push_back({tile_idx, 6'b0, block_idx, 16'h0, pe_w_data}); wi++; sw++;
            end
            if (s_i_valid && s_i_rdy) begin
                got_i.push_back({tile_idx, 6'b0, block_idx, 16'h0, pe_i_data}); ii++; si++;
            end
            if (s_o_valid && s_o_rdy) begin
                got_o.push_back({tile_idx, 6'b0, block_idx, 16'h0, pe_o_data}); oi++; so++;
            end
            xm = m_valid && m_rdy;
            prev_last_out = xm && (sout == 3);
            if (xm) begin
                got_m.push_back(m_data); pi++; sout++;
            end
            if (done === 1'b1) done_cnt++;

            prev_active = active;
            prev_full   = full;
            prev_drain  = drain_exp;
            prev_done   = (done === 1'b1);
            prev_block  = bi;
            prev_tile   = ti;
            if (done_cnt > 0 && done === 1'b0 && busy === 1'b0) finished = 1'b1;
        end
        start = 1'b0;

        check({s.name, "_finished"}, 64'(finished), 64'd1);
        check({s.name, "_protocol_violations"}, 64'(viol), 64'd0);
        check({s.name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({s.name, "_w_words"}, 64'(got_w.size()), 64'(s.exp_w));
        check({s.name, "_i_words"}, 64'(got_i.size()), 64'(s.exp_i));
        check({s.name, "_o_words"}, 64'(got_o.size()), 64'(s.exp_o));
        check({s.name, "_m_words"}, 64'(got_m.size()), 64'(s.exp_m));

        n = (got_w.size() < s.exp_w) ? got_w.size() : s.exp_w;
        for (int k = 0; k < n; k++)
            check($sformatf("%s_w[%0d]", s.name, k), got_w[k],
                  tag(k / 16, (k / 4) % 4, 32'(5 * (k + 1))));
        n = (got_i.size() < s.exp_i) ? got_i.size() : s.exp_i;
        for (int k = 0; k < n; k++)
            check($sformatf("%s_i[%0d]", s.name, k), got_i[k],
                  tag(k / 19, (k % 19 < 7) ? 0 : 1 + (k % 19 - 7) / 4, 32'(k + 1)));
        n = (got_o.size() < s.exp_o) ? got_o.size() : s.exp_o;
        for (int k = 0; k < n; k++)
            check($sformatf("%s_o[%0d]", s.name, k), got_o[k],
                  tag(k / 4, 0, 32'(10 * (k + 1))));
        n = (got_m.size() < s.exp_m) ? got_m.size() : s.exp_m;
        for (int k = 0; k < n; k++)
            check($sformatf("%s_m[%0d]", s.name, k), 64'(got_m[k]),
                  64'(32'hA000_0000 + 32'(k)));
    endtask

    initial begin
        int n;
        tbl[0] = '{"t1_single",    1, 1'b0, 1'b0, 1'b0, 1'b0, 16, 19,  4,  4};
        tbl[1] = '{"t2_backpress", 1, 1'b1, 1'b1, 1'b0, 1'b0, 16, 19,  4,  4};
        tbl[2] = '{"t3_src_stall", 1, 1'b0, 1'b0, 1'b1, 1'b0, 16, 19,  4,  4};
        tbl[3] = '{"t5_three",     3, 1'b0, 1'b0, 1'b0, 1'b1, 48, 57, 12, 12};
        tbl[4] = '{"mixed_two",    2, 1'b1, 1'b1, 1'b1, 1'b0, 32, 38,  8,  8};

        // Reset state with every upstream/downstream handshake input asserted.
        aclr_n = 1'b0; start = 1'b0; num_tiles = '0;
        drive_all_ready();
        #3;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_tile_idx", 64'(tile_idx), 64'd0);
        check("reset_block_idx", 64'(block_idx), 64'd0);
        check("reset_handshakes", 64'(hs_bundle()), 64'd0);
        @(negedge clk);
        aclr_n = 1'b1;

        foreach (tbl[k]) run_scenario(tbl[k]);

        // Zero tiles: straight to FIN, one done pulse, no stream ever opened.
        drive_all_ready();
        @(posedge clk); #1;
        start = 1'b1; num_tiles = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_done_pulse", 64'(done), 64'd1);
        check("t4_busy_in_fin", 64'(busy), 64'd1);
        @(negedge clk);
        check("t4_handshakes_fin", 64'(hs_bundle()), 64'd0);
        @(posedge clk); #1;
        check("t4_done_cleared", 64'(done), 64'd0);
        check("t4_busy_cleared", 64'(busy), 64'd0);
        check("t4_handshakes_idle", 64'(hs_bundle()), 64'd0);

        // Asynchronous abort in the middle of block 1.
        @(posedge clk); #1;
        start = 1'b1; num_tiles = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (block_idx !== 2'd1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_reached_block1", 64'(block_idx), 64'd1);
        check("t6_streams_open", 64'(pe_w_valid & s_w_rdy), 64'd1);
        #2 aclr_n = 1'b0;
        #1;
        check("t6_abort_busy", 64'(busy), 64'd0);
        check("t6_abort_done", 64'(done), 64'd0);
        check("t6_abort_tile_idx", 64'(tile_idx), 64'd0);
        check("t6_abort_block_idx", 64'(block_idx), 64'd0);
        check("t6_abort_handshakes", 64'(hs_bundle()), 64'd0);
        @(negedge clk);
        aclr_n = 1'b1;

        // A fresh single-tile run after the abort.
        begin
            scen_t again;
            again = tbl[0];
            again.name = "t6_rerun";
            run_scenario(again);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
